// File: rtl/icache_direct_if.sv
// Fetch-unit and memory-controller signals of the direct-mapped instruction cache.
// The slave modport is the cache side; the master modport is the fetch unit plus the controller.
interface icache_direct_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_ins;
    logic        is_fetch;
    logic [31:0] fetch_addr;
    logic        is_back;
    logic [31:0] back_ins;

    modport slave (
        input  if_req, if_addr, is_back, back_ins,
        output if_ready, if_valid, if_ins, is_fetch, fetch_addr
    );

    modport master (
        output if_req, if_addr, is_back, back_ins,
        input  if_ready, if_valid, if_ins, is_fetch, fetch_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    input  logic            clear_in,
    input  logic            inv_in,
    icache_direct_if.slave  bus,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                state, state_nx;
    logic [LINES-1:0]      valid, valid_nx;
    logic [TAG_BITS-1:0]   tag_mem [LINES];
    logic [31:0]           data_mem [LINES];
    logic [INDEX_BITS-1:0] req_idx, miss_idx, miss_idx_nx;
    logic [TAG_BITS-1:0]   req_tag, miss_tag, miss_tag_nx;
    logic                  stale, stale_nx;
    logic                  out_valid, out_valid_nx;
    logic [31:0]           out_ins, out_ins_nx;
    logic                  fetch, fetch_nx;
    logic [31:0]           fetch_addr_q, fetch_addr_nx;
    logic                  ready, accept, hit, fill;

    assign req_idx = bus.if_addr[INDEX_BITS+1:2];
    assign req_tag = bus.if_addr[31:INDEX_BITS+2];
    assign ready   = (state == IDLE) && !clear_in && !inv_in;
    assign accept  = bus.if_req && ready;
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill    = (state != IDLE) && bus.is_back;

    assign bus.if_ready   = ready;
    assign bus.if_valid   = out_valid;
    assign bus.if_ins     = out_ins;
    assign bus.is_fetch   = fetch;
    assign bus.fetch_addr = fetch_addr_q;

    always_comb begin
        state_nx      = state;
        valid_nx      = valid;
        miss_idx_nx   = miss_idx;
        miss_tag_nx   = miss_tag;
        stale_nx      = stale;
        out_valid_nx  = 1'b0;
        out_ins_nx    = out_ins;
        fetch_nx      = fetch;
        fetch_addr_nx = fetch_addr_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        out_valid_nx = 1'b1;
                        out_ins_nx   = data_mem[req_idx];
                    end else begin
                        state_nx      = MISS;
                        fetch_nx      = 1'b1;
                        fetch_addr_nx = bus.if_addr & 32'hFFFF_FFFC;
                        miss_idx_nx   = req_idx;
                        miss_tag_nx   = req_tag;
                    end
                end
            end
            MISS: begin
                if (bus.is_back) begin
                    state_nx     = IDLE;
                    fetch_nx     = 1'b0;
                    out_valid_nx = !clear_in;
                    out_ins_nx   = bus.back_ins;
                end else if (clear_in) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.is_back) begin
                    state_nx = IDLE;
                    fetch_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        // An invalidate racing an outstanding miss must keep that fill from becoming valid.
        if (inv_in && (state != IDLE)) begin
            stale_nx = 1'b1;
        end
        if (fill) begin
            valid_nx[miss_idx] = !stale;
            stale_nx           = 1'b0;
        end
        if (inv_in) begin
            valid_nx = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            valid        <= '0;
            miss_idx     <= '0;
            miss_tag     <= '0;
            stale        <= 1'b0;
            out_valid    <= 1'b0;
            out_ins      <= '0;
            fetch        <= 1'b0;
            fetch_addr_q <= '0;
        end else if (rdy_in) begin
            state        <= state_nx;
            valid        <= valid_nx;
            miss_idx     <= miss_idx_nx;
            miss_tag     <= miss_tag_nx;
            stale        <= stale_nx;
            out_valid    <= out_valid_nx;
            out_ins      <= out_ins_nx;
            fetch        <= fetch_nx;
            fetch_addr_q <= fetch_addr_nx;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.back_ins;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (rdy_in && accept) begin
            if (hit) begin
                hit_q <= hit_q + 32'd1;
            end else begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Randomized self-checking bench for icache_direct against a line-map reference model.
module tb_icache_direct;
    localparam int IB    = 6;
    localparam int LINES = 1 << IB;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_in;
    logic        inv_in;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_direct_if bus();

    icache_direct #(.INDEX_BITS(IB)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .inv_in   (inv_in),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad   = 0;
    bit          mvalid [LINES];
    logic [31:0] maddr  [LINES];
    logic [31:0] mdata  [LINES];
    int unsigned expHits;
    int unsigned expMisses;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int lineOf(input logic [31:0] a);
        return int'((a >> 2) & (LINES - 1));
    endfunction

    task automatic modelInvalidate();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic modelReset();
        modelInvalidate();
        expHits   = 0;
        expMisses = 0;
    endtask

    task automatic checkCounters();
`ifdef ICACHE_STAT_EN
        checkOutput("hit_cnt", hit_cnt, expHits);
        checkOutput("miss_cnt", miss_cnt, expMisses);
`else
        checkOutput("hit_cnt", hit_cnt, 32'd0);
        checkOutput("miss_cnt", miss_cnt, 32'd0);
`endif
    endtask

    // One fetch transaction; on a miss the controller answers after lat idle cycles.
    // clrPos/invPos select the miss cycle carrying clear_in/inv_in (-1 = none, lat = with is_back).
    task automatic applyStimulus(input logic [31:0] addr, input int lat, input int clrPos,
                                 input int invPos, input logic [31:0] data);
        logic [31:0] aligned;
        int          idx;
        bit          isHit;
        aligned = addr & 32'hFFFF_FFFC;
        idx     = lineOf(aligned);
        isHit   = mvalid[idx] && (maddr[idx] == aligned);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        #1;
        checkOutput("req_ready", bus.if_ready, 1);
        tick();
        bus.if_req  = 1'b0;
        bus.if_addr = $urandom;
        if (isHit) begin
            expHits++;
            checkOutput("hit_valid", bus.if_valid, 1);
            checkOutput("hit_ins", bus.if_ins, mdata[idx]);
            checkOutput("hit_nofetch", bus.is_fetch, 0);
            return;
        end
        expMisses++;
        checkOutput("miss_fetch", bus.is_fetch, 1);
        checkOutput("miss_addr", bus.fetch_addr, aligned);
        checkOutput("miss_novalid", bus.if_valid, 0);
        for (int i = 0; i <= lat; i++) begin
            clear_in = (i == clrPos);
            inv_in   = (i == invPos);
            if (i == lat) begin
                bus.is_back  = 1'b1;
                bus.back_ins = data;
            end
            #1;
            checkOutput("miss_ready", bus.if_ready, 0);
            tick();
            clear_in    = 1'b0;
            inv_in      = 1'b0;
            bus.is_back = 1'b0;
            if (i < lat) begin
                checkOutput("hold_fetch", bus.is_fetch, 1);
                checkOutput("hold_addr", bus.fetch_addr, aligned);
                checkOutput("hold_novalid", bus.if_valid, 0);
            end
        end
        if (invPos >= 0) modelInvalidate();
        maddr[idx]  = aligned;
        mdata[idx]  = data;
        mvalid[idx] = (invPos < 0);
        checkOutput("fill_fetch", bus.is_fetch, 0);
        checkOutput("fill_valid", bus.if_valid, (clrPos < 0) ? 32'd1 : 32'd0);
        if (clrPos < 0) checkOutput("fill_ins", bus.if_ins, data);
        #1;
        checkOutput("fill_ready", bus.if_ready, 1);
    endtask

    task automatic applyInvalidate();
        inv_in      = 1'b1;
        bus.if_req  = 1'($urandom_range(0, 1));
        bus.if_addr = $urandom;
        #1;
        checkOutput("inv_ready", bus.if_ready, 0);
        tick();
        inv_in     = 1'b0;
        bus.if_req = 1'b0;
        modelInvalidate();
        checkOutput("inv_novalid", bus.if_valid, 0);
    endtask

    task automatic applyIdleClear();
        clear_in    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1000 + ($urandom_range(0, 7) << 2);
        #1;
        checkOutput("clr_ready", bus.if_ready, 0);
        tick();
        clear_in   = 1'b0;
        bus.if_req = 1'b0;
        checkOutput("clr_novalid", bus.if_valid, 0);
        checkOutput("clr_nofetch", bus.is_fetch, 0);
    endtask

    task automatic applyStrayBack();
        bus.is_back  = 1'b1;
        bus.back_ins = $urandom;
        tick();
        bus.is_back = 1'b0;
        checkOutput("stray_fetch", bus.is_fetch, 0);
        checkOutput("stray_valid", bus.if_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r, lat, cp, ip;
        rst_n_in     = 1'b0;
        rdy_in       = 1'b1;
        clear_in     = 1'b0;
        inv_in       = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.is_back  = 1'b0;
        bus.back_ins = '0;
        modelReset();
        #12;
        checkOutput("rst_valid", bus.if_valid, 0);
        checkOutput("rst_fetch", bus.is_fetch, 0);
        checkOutput("rst_faddr", bus.fetch_addr, 0);
        checkOutput("rst_ins", bus.if_ins, 0);
        rst_n_in = 1'b1;
        tick();
        checkOutput("rst_ready", bus.if_ready, 1);
        checkCounters();

        $display("[TB] cold miss, hits, conflict");
        applyStimulus(32'h0000_1006, 4, -1, -1, 32'h0050_0093);
        checkCounters();
        for (int i = 0; i < 3; i++) applyStimulus(32'h0000_1004, 0, -1, -1, 32'h0);
        checkCounters();
        applyStimulus(32'h0000_1104, 2, -1, -1, 32'hAAAA_0001);
        applyStimulus(32'h0000_1004, 1, -1, -1, 32'h0050_0093);

        $display("[TB] clear and invalidate");
        applyStimulus(32'h0000_2000, 3, 1, -1, 32'h1234_5678);
        applyStimulus(32'h0000_2000, 0, -1, -1, 32'h0);
        applyInvalidate();
        applyStimulus(32'h0000_1004, 2, -1, -1, 32'h0050_0093);
        applyStimulus(32'h0000_3000, 3, -1, 1, 32'hCAFE_0001);
        applyStimulus(32'h0000_3000, 1, -1, -1, 32'hCAFE_0002);
        applyStimulus(32'h0000_3100, 2, 2, -1, 32'hCAFE_0003);
        applyStimulus(32'h0000_3100, 0, -1, -1, 32'h0);
        applyStimulus(32'h0000_3200, 2, -1, 2, 32'hCAFE_0004);
        applyStimulus(32'h0000_3200, 1, -1, -1, 32'hCAFE_0005);
        applyStrayBack();

        $display("[TB] freeze");
        applyStimulus(32'h0000_3200, 0, -1, -1, 32'h0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_hold_valid", bus.if_valid, 1);
            checkOutput("frz_hold_ins", bus.if_ins, 32'hCAFE_0005);
        end
        rdy_in = 1'b1;
        tick();
        checkOutput("frz_release", bus.if_valid, 0);
        rdy_in      = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_3200;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_req_valid", bus.if_valid, 0);
        end
        rdy_in = 1'b1;
        tick();
        bus.if_req = 1'b0;
        expHits++;
        checkOutput("frz_resp_valid", bus.if_valid, 1);
        checkOutput("frz_resp_ins", bus.if_ins, 32'hCAFE_0005);
        checkCounters();

        $display("[TB] reset during miss");
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_5000;
        tick();
        bus.if_req = 1'b0;
        checkOutput("rim_fetch", bus.is_fetch, 1);
        #2 rst_n_in = 1'b0;
        #1;
        checkOutput("rim_fetch_rst", bus.is_fetch, 0);
        checkOutput("rim_valid_rst", bus.if_valid, 0);
        modelReset();
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        tick();
        checkOutput("rim_ready", bus.if_ready, 1);
        checkCounters();
        applyStimulus(32'h0000_2000, 1, -1, -1, 32'h8765_4321);

        $display("[TB] random phase");
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                a   = 32'h0000_1000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 7) << 2)
                      + $urandom_range(0, 3);
                lat = $urandom_range(0, 4);
                cp  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
                ip  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, lat) : -1;
                applyStimulus(a, lat, cp, ip, $urandom);
            end else if (r < 87) begin
                applyInvalidate();
            end else if (r < 94) begin
                applyIdleClear();
            end else begin
                applyStrayBack();
            end
        end
        checkCounters();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
